// File: rtl/bullet_ctrl_if.sv
// Bundle of the bullet launch handshake and the single-pixel VGA plot port.
// The controller drives it through the master modport; the mover/screen side uses slave.
interface bullet_ctrl_if;
    logic       load;
    logic       shooting;
    logic       collision;
    logic [7:0] start_x;
    logic [6:0] start_y;
    logic [1:0] direction_x;
    logic [1:0] direction_y;
    logic       firing;
    logic       plot_bullet;
    logic [7:0] curr_x;
    logic [6:0] curr_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output load, shooting, collision, start_x, start_y, direction_x, direction_y,
        output vga_x, vga_y, vga_colour, vga_plot,
        input  firing, plot_bullet, curr_x, curr_y
    );

    modport slave (
        input  load, shooting, collision, start_x, start_y, direction_x, direction_y,
        input  vga_x, vga_y, vga_colour, vga_plot,
        output firing, plot_bullet, curr_x, curr_y
    );
endinterface

// File: rtl/bullet_ctrl.sv
// Fire control, erase/redraw plotting and asteroid hit test for the bullet mover.
// Optional macro BULLET_CTRL_AUTOFIRE_EN: a held fire button re-fires after every cooldown.
module bullet_ctrl #(
    parameter logic [23:0] COOLDOWN_CYCLES = 24'd1000,
    parameter int          ROCK_W          = 8,
    parameter int          ROCK_H          = 8,
    parameter logic [2:0]  BULLET_COLOUR   = 3'b111,
    parameter int          LAUNCH_TIMEOUT  = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_fire_btn,
    input  logic [7:0]    i_ship_x,
    input  logic [6:0]    i_ship_y,
    input  logic [1:0]    i_ship_dir_x,
    input  logic [1:0]    i_ship_dir_y,
    input  logic [7:0]    i_rock_x,
    input  logic [6:0]    i_rock_y,
    input  logic          i_rock_valid,
    bullet_ctrl_if.master bus,
    output logic          o_hit
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_LAUNCH   = 4'd2,
        ST_FLY      = 4'd3,
        ST_ERASE    = 4'd4,
        ST_DRAW     = 4'd5,
        ST_HIT      = 4'd6,
        ST_FINAL    = 4'd7,
        ST_COOLDOWN = 4'd8
    } state_t;

    localparam logic [8:0] ROCK_W_M1   = 9'(ROCK_W - 1);
    localparam logic [7:0] ROCK_H_M1   = 8'(ROCK_H - 1);
    localparam logic [7:0] LAUNCH_LAST = 8'(LAUNCH_TIMEOUT - 1);
    localparam logic [2:0] ERASE_COLOUR = 3'b000;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_start_x,    w_start_x;
    logic [6:0]  r_start_y,    w_start_y;
    logic [1:0]  r_dir_x,      w_dir_x;
    logic [1:0]  r_dir_y,      w_dir_y;
    logic [7:0]  r_last_x,     w_last_x;
    logic [6:0]  r_last_y,     w_last_y;
    logic        r_drawn_valid, w_drawn_valid;
    logic [7:0]  r_launch_cnt, w_launch_cnt;
    logic [23:0] r_cool_cnt,   w_cool_cnt;
    logic        r_load,       w_load;
    logic        r_shooting,   w_shooting;
    logic        r_collision,  w_collision;
    logic        r_hit,        w_hit;
    logic [7:0]  r_vga_x,      w_vga_x;
    logic [6:0]  r_vga_y,      w_vga_y;
    logic [2:0]  r_vga_colour, w_vga_colour;
    logic        r_vga_plot,   w_vga_plot;

    logic        w_fire_evt;
    logic        w_in_x;
    logic        w_in_y;
    logic        w_rock_hit;
    logic        w_moved;

`ifdef BULLET_CTRL_AUTOFIRE_EN
    assign w_fire_evt = i_fire_btn;
`else
    logic r_fire_prev;

    // Previous fire button level for rising-edge detection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fire_prev <= 1'b0;
        end else begin
            r_fire_prev <= i_fire_btn;
        end
    end

    assign w_fire_evt = i_fire_btn & ~r_fire_prev;
`endif

    // Box bounds are widened by one bit so a rock at the screen edge cannot wrap.
    assign w_in_x = ({1'b0, bus.curr_x} >= {1'b0, i_rock_x}) &&
                    ({1'b0, bus.curr_x} <= ({1'b0, i_rock_x} + ROCK_W_M1));
    assign w_in_y = ({1'b0, bus.curr_y} >= {1'b0, i_rock_y}) &&
                    ({1'b0, bus.curr_y} <= ({1'b0, i_rock_y} + ROCK_H_M1));
    assign w_rock_hit = i_rock_valid && w_in_x && w_in_y;
    assign w_moved    = (bus.curr_x != r_last_x) || (bus.curr_y != r_last_y);

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        w_next        = r_state;
        w_start_x     = r_start_x;
        w_start_y     = r_start_y;
        w_dir_x       = r_dir_x;
        w_dir_y       = r_dir_y;
        w_last_x      = r_last_x;
        w_last_y      = r_last_y;
        w_drawn_valid = r_drawn_valid;
        w_launch_cnt  = r_launch_cnt;
        w_cool_cnt    = r_cool_cnt;
        w_load        = 1'b0;
        w_shooting    = 1'b0;
        w_collision   = 1'b0;
        w_hit         = 1'b0;
        w_vga_x       = r_vga_x;
        w_vga_y       = r_vga_y;
        w_vga_colour  = r_vga_colour;
        w_vga_plot    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_fire_evt) begin
                    w_start_x = i_ship_x;
                    w_start_y = i_ship_y;
                    w_dir_x   = i_ship_dir_x;
                    w_dir_y   = i_ship_dir_y;
                    if ((i_ship_dir_x != 2'b00) || (i_ship_dir_y != 2'b00)) begin
                        w_next = ST_LOAD;
                        w_load = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end

            ST_LOAD: begin
                w_next        = ST_LAUNCH;
                w_shooting    = 1'b1;
                w_drawn_valid = 1'b0;
                w_launch_cnt  = 8'd0;
            end

            ST_LAUNCH: begin
                if (bus.firing) begin
                    w_next = ST_FLY;
                end else if (r_launch_cnt >= LAUNCH_LAST) begin
                    w_next = ST_IDLE;
                end else begin
                    w_launch_cnt = r_launch_cnt + 8'd1;
                    w_shooting   = 1'b1;
                end
            end

            ST_FLY: begin
                // Hit outranks edge exit, which outranks a redraw.
                if (w_rock_hit) begin
                    w_next      = ST_HIT;
                    w_collision = 1'b1;
                    w_hit       = 1'b1;
                    if (r_drawn_valid) begin
                        w_vga_plot   = 1'b1;
                        w_vga_x      = r_last_x;
                        w_vga_y      = r_last_y;
                        w_vga_colour = ERASE_COLOUR;
                    end else begin
                        w_vga_plot = 1'b0;
                    end
                    w_drawn_valid = 1'b0;
                end else if (!bus.firing) begin
                    w_next = ST_FINAL;
                    if (r_drawn_valid) begin
                        w_vga_plot   = 1'b1;
                        w_vga_x      = r_last_x;
                        w_vga_y      = r_last_y;
                        w_vga_colour = ERASE_COLOUR;
                    end else begin
                        w_vga_plot = 1'b0;
                    end
                    w_drawn_valid = 1'b0;
                end else if (bus.plot_bullet && (w_moved || !r_drawn_valid)) begin
                    if (r_drawn_valid) begin
                        w_next       = ST_ERASE;
                        w_vga_plot   = 1'b1;
                        w_vga_x      = r_last_x;
                        w_vga_y      = r_last_y;
                        w_vga_colour = ERASE_COLOUR;
                    end else begin
                        w_next        = ST_DRAW;
                        w_vga_plot    = 1'b1;
                        w_vga_x       = bus.curr_x;
                        w_vga_y       = bus.curr_y;
                        w_vga_colour  = BULLET_COLOUR;
                        w_last_x      = bus.curr_x;
                        w_last_y      = bus.curr_y;
                        w_drawn_valid = 1'b1;
                    end
                end else begin
                    w_next = ST_FLY;
                end
            end

            ST_ERASE: begin
                // Draw position is whatever the mover reports as DRAW is entered.
                w_next        = ST_DRAW;
                w_vga_plot    = 1'b1;
                w_vga_x       = bus.curr_x;
                w_vga_y       = bus.curr_y;
                w_vga_colour  = BULLET_COLOUR;
                w_last_x      = bus.curr_x;
                w_last_y      = bus.curr_y;
                w_drawn_valid = 1'b1;
            end

            ST_DRAW: begin
                w_next = ST_FLY;
            end

            ST_HIT, ST_FINAL: begin
                w_next     = ST_COOLDOWN;
                w_cool_cnt = COOLDOWN_CYCLES;
            end

            ST_COOLDOWN: begin
                if (r_cool_cnt <= 24'd1) begin
                    w_next     = ST_IDLE;
                    w_cool_cnt = 24'd0;
                end else begin
                    w_next     = ST_COOLDOWN;
                    w_cool_cnt = r_cool_cnt - 24'd1;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath and registered outputs; reset leaves any drawn pixel for screen clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_start_x     <= 8'd0;
            r_start_y     <= 7'd0;
            r_dir_x       <= 2'b00;
            r_dir_y       <= 2'b00;
            r_last_x      <= 8'd0;
            r_last_y      <= 7'd0;
            r_drawn_valid <= 1'b0;
            r_launch_cnt  <= 8'd0;
            r_cool_cnt    <= 24'd0;
            r_load        <= 1'b0;
            r_shooting    <= 1'b0;
            r_collision   <= 1'b0;
            r_hit         <= 1'b0;
            r_vga_x       <= 8'd0;
            r_vga_y       <= 7'd0;
            r_vga_colour  <= 3'b000;
            r_vga_plot    <= 1'b0;
        end else begin
            r_start_x     <= w_start_x;
            r_start_y     <= w_start_y;
            r_dir_x       <= w_dir_x;
            r_dir_y       <= w_dir_y;
            r_last_x      <= w_last_x;
            r_last_y      <= w_last_y;
            r_drawn_valid <= w_drawn_valid;
            r_launch_cnt  <= w_launch_cnt;
            r_cool_cnt    <= w_cool_cnt;
            r_load        <= w_load;
            r_shooting    <= w_shooting;
            r_collision   <= w_collision;
            r_hit         <= w_hit;
            r_vga_x       <= w_vga_x;
            r_vga_y       <= w_vga_y;
            r_vga_colour  <= w_vga_colour;
            r_vga_plot    <= w_vga_plot;
        end
    end

    assign bus.load        = r_load;
    assign bus.shooting    = r_shooting;
    assign bus.collision   = r_collision;
    assign bus.start_x     = r_start_x;
    assign bus.start_y     = r_start_y;
    assign bus.direction_x = r_dir_x;
    assign bus.direction_y = r_dir_y;
    assign bus.vga_x       = r_vga_x;
    assign bus.vga_y       = r_vga_y;
    assign bus.vga_colour  = r_vga_colour;
    assign bus.vga_plot    = r_vga_plot;
    assign o_hit           = r_hit;

endmodule
